// File: rtl/stopwatch_seq_ctrl_pkg.sv
// Shared definitions for the stopwatch sequencing controller.
// State encoding and count-direction constants used across the timer blocks.
package stopwatch_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        LAP  = 3'd4,
        STOP = 3'd5,
        DONE = 3'd6
    } state_e;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/stopwatch_seq_ctrl_if.sv
// Button/lock inputs and timer control outputs of the stopwatch controller.
// master drives the buttons and lock; slave is the controller.
interface stopwatch_seq_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              dcm_lock;
    logic              strtstop;
    logic              lap_load;
    logic              mode_in;
    logic              time_zero;
    logic              clken;
    logic              rst_int;
    logic              load;
    logic              lap_trigger;
    logic              mode;
    logic [ADDR_W-1:0] preset_addr;

    modport master (
        output dcm_lock, strtstop, lap_load, mode_in, time_zero,
        input  clken, rst_int, load, lap_trigger, mode, preset_addr
    );

    modport slave (
        input  dcm_lock, strtstop, lap_load, mode_in, time_zero,
        output clken, rst_int, load, lap_trigger, mode, preset_addr
    );
endinterface

// File: rtl/stopwatch_seq_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
// rise is high for the cycle the level is 1 and was 0 on the previous edge.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic prev_q;
    logic prev_d;

    // previous level is simply the current level one edge later
    always_comb begin
        prev_d = level;
    end

    // prev register, cleared so a button held through reset reads as a rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;
endmodule

// File: rtl/stopwatch_seq_ctrl.sv
// Stopwatch control FSM: sequences count enable, clear, preset load,
// lap freeze and count direction, and walks the preset ROM address.
module stopwatch_seq_ctrl
    import stopwatch_seq_ctrl_pkg::*;
#(
    parameter int RST_HOLD = 4,
    parameter int ADDR_W   = 6
) (
    input logic           clk,
    input logic           reset,
    stopwatch_seq_ctrl_if.slave bus
);
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mode_q, mode_d;
    logic              clken_q, clken_d;
    logic              rst_int_q, rst_int_d;
    logic              load_q, load_d;
    logic              lap_q, lap_d;
    logic              clear;

    logic s_rise, l_rise, m_rise;
    logic go_s, go_l, go_m;
    logic zero_hit;

    btn_edge u_strt (
        .clk   (clk),
        .reset (reset),
        .level (bus.strtstop),
        .rise  (s_rise)
    );

    btn_edge u_lap (
        .clk   (clk),
        .reset (reset),
        .level (bus.lap_load),
        .rise  (l_rise)
    );

    btn_edge u_mode (
        .clk   (clk),
        .reset (reset),
        .level (bus.mode_in),
        .rise  (m_rise)
    );

    // one button event per cycle: start/stop beats lap/load beats mode
    always_comb begin
        go_s     = s_rise;
        go_l     = l_rise & ~s_rise;
        go_m     = m_rise & ~s_rise & ~l_rise;
        zero_hit = (mode_q == MODE_DOWN) & bus.time_zero;
    end

    // next state, hold counter, address/mode updates and registered outputs
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        addr_d  = addr_q;
        mode_d  = mode_q;
        clear   = 1'b0;

        if (!bus.dcm_lock) begin
            state_d = INIT;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (go_s) begin
                        state_d = RUN;
                    end else if (go_l) begin
                        if (mode_q == MODE_DOWN) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = LOAD;
                        end
                    end else if (go_m) begin
                        mode_d = ~mode_q;
                        if (mode_q == MODE_UP) begin
                            addr_d  = '0;
                            state_d = LOAD;
                        end else begin
                            clear = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (go_s) begin
                        state_d = STOP;
                    end else if (go_l) begin
                        state_d = LAP;
                    end else if (zero_hit) begin
                        state_d = DONE;
                    end
                end
                LAP: begin
                    if (go_s) begin
                        state_d = STOP;
                    end else if (go_l) begin
                        state_d = RUN;
                    end else if (zero_hit) begin
                        state_d = DONE;
                    end
                end
                STOP: begin
                    if (go_s) begin
                        state_d = RUN;
                    end else if (go_l) begin
                        if (mode_q == MODE_UP) begin
                            clear   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                DONE: begin
                    if (go_s || go_l) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end

        clken_d   = (state_d == RUN) || (state_d == LAP);
        lap_d     = (state_d == LAP);
        rst_int_d = (state_d == INIT) || clear;
        load_d    = bus.dcm_lock && (state_q == LOAD);
    end

    // all state and outputs registered; reset lands in INIT counting up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            hold_q    <= '0;
            addr_q    <= '0;
            mode_q    <= MODE_UP;
            clken_q   <= 1'b0;
            rst_int_q <= 1'b1;
            load_q    <= 1'b0;
            lap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            clken_q   <= clken_d;
            rst_int_q <= rst_int_d;
            load_q    <= load_d;
            lap_q     <= lap_d;
        end
    end

    assign bus.clken       = clken_q;
    assign bus.rst_int     = rst_int_q;
    assign bus.load        = load_q;
    assign bus.lap_trigger = lap_q;
    assign bus.mode        = mode_q;
    assign bus.preset_addr = addr_q;
endmodule
